// File: rtl/dispatch_unit.sv
// Reader end of the ID2 issue queue: buffers one instruction pair, checks it against
// the int/fp scoreboard and within the pair, and issues in order on two registered ports.
module dispatch_unit #(
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               q_valid,
  output logic               read_en,
  input  logic               q1_i_nop,
  input  logic               q1_mem_wen,
  input  logic               q1_int_wen,
  input  logic               q1_fp_wen,
  input  logic [5:0]         q1_opcode,
  input  logic [2:0]         q1_detail,
  input  logic [3:0]         q1_rel,
  input  logic [4:0]         q1_src_a,
  input  logic [4:0]         q1_src_b,
  input  logic [4:0]         q1_dest,
  input  logic [31:0]        q1_pc,
  input  logic               q2_i_nop,
  input  logic               q2_mem_wen,
  input  logic               q2_int_wen,
  input  logic               q2_fp_wen,
  input  logic [5:0]         q2_opcode,
  input  logic [2:0]         q2_detail,
  input  logic [3:0]         q2_rel,
  input  logic [4:0]         q2_src_a,
  input  logic [4:0]         q2_src_b,
  input  logic [4:0]         q2_dest,
  input  logic [31:0]        q2_pc,
  input  logic               ex_ready0,
  input  logic               ex_ready1,
  input  logic               wb_int_en,
  input  logic [4:0]         wb_int_reg,
  input  logic               wb_fp_en,
  input  logic [4:0]         wb_fp_reg,
  input  logic               flush,
  output logic               d0_valid,
  output logic [5:0]         d0_opcode,
  output logic [2:0]         d0_detail,
  output logic [4:0]         d0_src_a,
  output logic [4:0]         d0_src_b,
  output logic [4:0]         d0_dest,
  output logic               d0_mem_wen,
  output logic               d0_int_wen,
  output logic               d0_fp_wen,
  output logic [31:0]        d0_pc,
  output logic               d1_valid,
  output logic [5:0]         d1_opcode,
  output logic [2:0]         d1_detail,
  output logic [4:0]         d1_src_a,
  output logic [4:0]         d1_src_b,
  output logic [4:0]         d1_dest,
  output logic               d1_mem_wen,
  output logic               d1_int_wen,
  output logic               d1_fp_wen,
  output logic [31:0]        d1_pc,
  output logic [STALL_W-1:0] stall_cnt
);

  typedef struct packed {
    logic        nop;
    logic        mem_wen;
    logic        int_wen;
    logic        fp_wen;
    logic [5:0]  opcode;
    logic [2:0]  detail;
    logic [3:0]  rel;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  dest;
    logic [31:0] pc;
  } inst_t;

  typedef enum logic [1:0] {IDLE, FULL, HALF} state_t;

  state_t             r_state, w_next;
  inst_t              r_i1, r_i2, r_d0, r_d1, w_q1, w_q2;
  logic [31:0]        r_busy_int, r_busy_fp;
  logic               r_d0_valid, r_d1_valid;
  logic [STALL_W-1:0] r_stall;

  logic        w_haz1, w_haz2, w_raw12, w_ok1, w_port2, w_ok2_full, w_ok2_half;
  logic        w_disp1, w_disp2, w_all, w_stall, w_v1, w_v2, w_p0_v, w_p1_v;
  logic [31:0] w_m1_int, w_m1_fp, w_set_int, w_set_fp, w_clr_int, w_clr_fp;

  assign w_q1 = '{nop: q1_i_nop, mem_wen: q1_mem_wen, int_wen: q1_int_wen, fp_wen: q1_fp_wen,
                  opcode: q1_opcode, detail: q1_detail, rel: q1_rel, src_a: q1_src_a,
                  src_b: q1_src_b, dest: q1_dest, pc: q1_pc};
  assign w_q2 = '{nop: q2_i_nop, mem_wen: q2_mem_wen, int_wen: q2_int_wen, fp_wen: q2_fp_wen,
                  opcode: q2_opcode, detail: q2_detail, rel: q2_rel, src_a: q2_src_a,
                  src_b: q2_src_b, dest: q2_dest, pc: q2_pc};

  // Busy vectors are passed in so the same check serves the scoreboard and the in-pair dest.
  function automatic logic f_hazard(input inst_t x, input logic [31:0] bi, input logic [31:0] bf);
    f_hazard = (x.rel[0] && (x.rel[2] ? bf[x.src_a] : bi[x.src_a])) ||
               (x.rel[1] && (x.rel[3] ? bf[x.src_b] : bi[x.src_b])) ||
               (x.int_wen && bi[x.dest]) || (x.fp_wen && bf[x.dest]);
  endfunction

  assign w_m1_int   = (!r_i1.nop && r_i1.int_wen) ? ((32'd1 << r_i1.dest) & ~32'd1) : '0;
  assign w_m1_fp    = (!r_i1.nop && r_i1.fp_wen) ? (32'd1 << r_i1.dest) : '0;
  assign w_haz1     = f_hazard(r_i1, r_busy_int, r_busy_fp);
  assign w_haz2     = f_hazard(r_i2, r_busy_int, r_busy_fp);
  assign w_raw12    = f_hazard(r_i2, w_m1_int, w_m1_fp);
  assign w_ok1      = r_i1.nop || (!w_haz1 && ex_ready0);
  assign w_port2    = r_i1.nop ? ex_ready0 : ex_ready1;
  assign w_ok2_full = w_ok1 && (r_i2.nop || (!w_haz2 && !w_raw12 && w_port2));
  assign w_ok2_half = r_i2.nop || (!w_haz2 && ex_ready0);

  assign read_en = q_valid && !flush && w_all;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next  = r_state;
    w_disp1 = 1'b0;
    w_disp2 = 1'b0;
    w_all   = 1'b0;
    w_stall = 1'b0;
    case (r_state)
      IDLE: w_all = 1'b1;
      FULL: begin
        w_disp1 = w_ok1;
        w_disp2 = w_ok2_full;
        w_all   = w_ok2_full;
        w_stall = (!r_i1.nop && !w_ok1) || (!r_i2.nop && !w_ok2_full);
        if (w_ok2_full)  w_next = IDLE;
        else if (w_ok1)  w_next = HALF;
      end
      HALF: begin
        w_disp2 = w_ok2_half;
        w_all   = w_ok2_half;
        w_stall = !r_i2.nop && !w_ok2_half;
        if (w_ok2_half) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (read_en) w_next = FULL;
    if (flush) begin
      w_next  = IDLE;
      w_disp1 = 1'b0;
      w_disp2 = 1'b0;
      w_stall = 1'b0;
    end
  end

  // Nops retire without a port; the remaining instructions pack from port0.
  assign w_v1   = w_disp1 && !r_i1.nop;
  assign w_v2   = w_disp2 && !r_i2.nop;
  assign w_p0_v = w_v1 || w_v2;
  assign w_p1_v = w_v1 && w_v2;

  assign w_set_int = ((w_v1 && r_i1.int_wen) ? (32'd1 << r_i1.dest) : '0) |
                     ((w_v2 && r_i2.int_wen) ? (32'd1 << r_i2.dest) : '0);
  assign w_set_fp  = ((w_v1 && r_i1.fp_wen) ? (32'd1 << r_i1.dest) : '0) |
                     ((w_v2 && r_i2.fp_wen) ? (32'd1 << r_i2.dest) : '0);
  assign w_clr_int = wb_int_en ? (32'd1 << wb_int_reg) : '0;
  assign w_clr_fp  = wb_fp_en ? (32'd1 << wb_fp_reg) : '0;

  // NOTE: all state, pair buffer included, is reset so no X can leak into hazard checks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_i1       <= '0;
      r_i2       <= '0;
      r_busy_int <= '0;
      r_busy_fp  <= '0;
      r_d0_valid <= 1'b0;
      r_d1_valid <= 1'b0;
      r_d0       <= '0;
      r_d1       <= '0;
      r_stall    <= '0;
    end else begin
      // NOTE: non-blocking updates so every register sees the pre-edge values.
      r_state <= w_next;
      if (read_en) begin
        r_i1 <= w_q1;
        r_i2 <= w_q2;
      end
      // Set wins over a same-edge writeback; int r0 can never become busy.
      r_busy_int <= ((r_busy_int & ~w_clr_int) | w_set_int) & ~32'd1;
      r_busy_fp  <= (r_busy_fp & ~w_clr_fp) | w_set_fp;
      r_d0_valid <= w_p0_v;
      r_d1_valid <= w_p1_v;
      if (w_p0_v) r_d0 <= w_v1 ? r_i1 : r_i2;
      if (w_p1_v) r_d1 <= r_i2;
      if (w_stall && r_stall != '1) r_stall <= r_stall + STALL_W'(1);
    end
  end

  assign d0_valid   = r_d0_valid;
  assign d0_opcode  = r_d0.opcode;
  assign d0_detail  = r_d0.detail;
  assign d0_src_a   = r_d0.src_a;
  assign d0_src_b   = r_d0.src_b;
  assign d0_dest    = r_d0.dest;
  assign d0_mem_wen = r_d0.mem_wen;
  assign d0_int_wen = r_d0.int_wen;
  assign d0_fp_wen  = r_d0.fp_wen;
  assign d0_pc      = r_d0.pc;
  assign d1_valid   = r_d1_valid;
  assign d1_opcode  = r_d1.opcode;
  assign d1_detail  = r_d1.detail;
  assign d1_src_a   = r_d1.src_a;
  assign d1_src_b   = r_d1.src_b;
  assign d1_dest    = r_d1.dest;
  assign d1_mem_wen = r_d1.mem_wen;
  assign d1_int_wen = r_d1.int_wen;
  assign d1_fp_wen  = r_d1.fp_wen;
  assign d1_pc      = r_d1.pc;
  assign stall_cnt  = r_stall;

endmodule

// File: tb/tb_dispatch_unit.sv
// Bench for dispatch_unit: directed scenarios plus random traffic, all compared every cycle
// against an in-order list-of-pending-instructions model with bit-vector scoreboards.
module tb_dispatch_unit;
  localparam int SW = 6;

  typedef struct packed {
    logic        nop;
    logic        mem_wen;
    logic        int_wen;
    logic        fp_wen;
    logic [5:0]  opcode;
    logic [2:0]  detail;
    logic [3:0]  rel;
    logic [4:0]  src_a;
    logic [4:0]  src_b;
    logic [4:0]  dest;
    logic [31:0] pc;
  } ins_t;

  typedef struct {
    ins_t i1;
    ins_t i2;
  } pair_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic q_valid = 1'b0, read_en;
  ins_t q1 = '0, q2 = '0;
  logic ex_ready0 = 1'b0, ex_ready1 = 1'b0, wb_int_en = 1'b0, wb_fp_en = 1'b0, flush = 1'b0;
  logic [4:0] wb_int_reg = '0, wb_fp_reg = '0;
  logic d0_valid, d0_mem_wen, d0_int_wen, d0_fp_wen, d1_valid, d1_mem_wen, d1_int_wen, d1_fp_wen;
  logic [5:0] d0_opcode, d1_opcode;
  logic [2:0] d0_detail, d1_detail;
  logic [4:0] d0_src_a, d0_src_b, d0_dest, d1_src_a, d1_src_b, d1_dest;
  logic [31:0] d0_pc, d1_pc;
  logic [SW-1:0] stall_cnt;

  dispatch_unit #(.STALL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .q_valid(q_valid), .read_en(read_en),
    .q1_i_nop(q1.nop), .q1_mem_wen(q1.mem_wen), .q1_int_wen(q1.int_wen), .q1_fp_wen(q1.fp_wen),
    .q1_opcode(q1.opcode), .q1_detail(q1.detail), .q1_rel(q1.rel), .q1_src_a(q1.src_a),
    .q1_src_b(q1.src_b), .q1_dest(q1.dest), .q1_pc(q1.pc),
    .q2_i_nop(q2.nop), .q2_mem_wen(q2.mem_wen), .q2_int_wen(q2.int_wen), .q2_fp_wen(q2.fp_wen),
    .q2_opcode(q2.opcode), .q2_detail(q2.detail), .q2_rel(q2.rel), .q2_src_a(q2.src_a),
    .q2_src_b(q2.src_b), .q2_dest(q2.dest), .q2_pc(q2.pc),
    .ex_ready0(ex_ready0), .ex_ready1(ex_ready1),
    .wb_int_en(wb_int_en), .wb_int_reg(wb_int_reg), .wb_fp_en(wb_fp_en), .wb_fp_reg(wb_fp_reg),
    .flush(flush),
    .d0_valid(d0_valid), .d0_opcode(d0_opcode), .d0_detail(d0_detail), .d0_src_a(d0_src_a),
    .d0_src_b(d0_src_b), .d0_dest(d0_dest), .d0_mem_wen(d0_mem_wen), .d0_int_wen(d0_int_wen),
    .d0_fp_wen(d0_fp_wen), .d0_pc(d0_pc),
    .d1_valid(d1_valid), .d1_opcode(d1_opcode), .d1_detail(d1_detail), .d1_src_a(d1_src_a),
    .d1_src_b(d1_src_b), .d1_dest(d1_dest), .d1_mem_wen(d1_mem_wen), .d1_int_wen(d1_int_wen),
    .d1_fp_wen(d1_fp_wen), .d1_pc(d1_pc),
    .stall_cnt(stall_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  // Reference model: pending instructions oldest first, busy bit vectors, expected outputs.
  ins_t        pend[$];
  pair_t       iq[$];
  logic [31:0] ib = '0, fb = '0;
  bit          edv[2];
  ins_t        ed[2];
  int unsigned est = 0;

  bit c_qgate = 0, c_ex0 = 1, c_ex1 = 1, c_wbi = 0, c_wbf = 0, c_flush = 0;
  logic [4:0] c_wbi_reg = '0, c_wbf_reg = '0;

  bit   e_read, e_stall, last_read;
  int   n_ret;
  bit   g_v[2];
  ins_t g[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_busy(bit fp, logic [4:0] r, logic [31:0] bi, logic [31:0] bf);
    return fp ? bf[r] : (r != 0 && bi[r]);
  endfunction

  function automatic bit hz(ins_t x, logic [31:0] bi, logic [31:0] bf);
    bit h = 0;
    if (x.rel[0] && is_busy(x.rel[2], x.src_a, bi, bf)) h = 1;
    if (x.rel[1] && is_busy(x.rel[3], x.src_b, bi, bf)) h = 1;
    if (x.int_wen && is_busy(1'b0, x.dest, bi, bf)) h = 1;
    if (x.fp_wen && is_busy(1'b1, x.dest, bi, bf)) h = 1;
    return h;
  endfunction

  function automatic logic [63:0] flds(ins_t x);
    return 64'({x.opcode, x.detail, x.src_a, x.src_b, x.dest, x.mem_wen, x.int_wen, x.fp_wen});
  endfunction

  // Walk pending instructions in program order; each granted one reserves its dests
  // so a younger one in the same cycle sees them as busy.
  task automatic model_eval();
    logic [31:0] ti = ib, tf = fb;
    int port = 0;
    bit blocked = 0;
    bit rdy[2];
    rdy[0] = c_ex0; rdy[1] = c_ex1;
    n_ret = 0; g_v[0] = 0; g_v[1] = 0; e_stall = 0;
    for (int i = 0; i < pend.size(); i++) begin
      if (blocked) begin
        if (!pend[i].nop) e_stall = 1;
      end else if (pend[i].nop) begin
        n_ret++;
      end else if (port < 2 && rdy[port] && !hz(pend[i], ti, tf)) begin
        g_v[port] = 1; g[port] = pend[i]; port++; n_ret++;
        if (pend[i].int_wen && pend[i].dest != 0) ti[pend[i].dest] = 1'b1;
        if (pend[i].fp_wen) tf[pend[i].dest] = 1'b1;
      end else begin
        blocked = 1; e_stall = 1;
      end
    end
    e_read = c_qgate && iq.size() > 0 && !c_flush && (n_ret == pend.size());
    if (c_flush) begin
      g_v[0] = 0; g_v[1] = 0; n_ret = 0; e_stall = 0;
    end
  endtask

  task automatic model_update();
    if (c_wbi) ib[c_wbi_reg] = 1'b0;
    if (c_wbf) fb[c_wbf_reg] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (g_v[p] && g[p].int_wen && g[p].dest != 0) ib[g[p].dest] = 1'b1;
      if (g_v[p] && g[p].fp_wen) fb[g[p].dest] = 1'b1;
      edv[p] = g_v[p];
      if (g_v[p]) ed[p] = g[p];
    end
    if (e_stall && est != (1 << SW) - 1) est++;
    if (c_flush) pend.delete();
    else repeat (n_ret) void'(pend.pop_front());
    if (e_read) begin
      pend.push_back(iq[0].i1);
      pend.push_back(iq[0].i2);
      void'(iq.pop_front());
    end
  endtask

  task automatic model_reset();
    pend.delete(); iq.delete();
    ib = '0; fb = '0; est = 0;
    edv[0] = 0; edv[1] = 0; ed[0] = '0; ed[1] = '0;
  endtask

  // One clock: drive at negedge, compare just after, advance the model at posedge.
  task automatic step();
    @(negedge clk);
    ex_ready0 = c_ex0; ex_ready1 = c_ex1; flush = c_flush;
    wb_int_en = c_wbi; wb_int_reg = c_wbi_reg; wb_fp_en = c_wbf; wb_fp_reg = c_wbf_reg;
    model_eval();
    q_valid = c_qgate && iq.size() > 0;
    if (e_read) begin
      q1 = iq[0].i1; q2 = iq[0].i2;
    end else begin
      q1 = ins_t'({$urandom, $urandom}); q2 = ins_t'({$urandom, $urandom});
    end
    #1;
    last_read = read_en;
    check("read_en", read_en, e_read);
    check("d0_valid", d0_valid, edv[0]);
    check("d1_valid", d1_valid, edv[1]);
    check("stall_cnt", stall_cnt, est);
    if (edv[0]) begin
      check("d0_fields", 64'({d0_opcode, d0_detail, d0_src_a, d0_src_b, d0_dest, d0_mem_wen,
                              d0_int_wen, d0_fp_wen}), flds(ed[0]));
      check("d0_pc", d0_pc, ed[0].pc);
    end
    if (edv[1]) begin
      check("d1_fields", 64'({d1_opcode, d1_detail, d1_src_a, d1_src_b, d1_dest, d1_mem_wen,
                              d1_int_wen, d1_fp_wen}), flds(ed[1]));
      check("d1_pc", d1_pc, ed[1].pc);
    end
    @(posedge clk);
    model_update();
  endtask

  // Called just after a posedge (or at time 0): reset lands between edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    q_valid = 1'b0; flush = 1'b0; wb_int_en = 1'b0; wb_fp_en = 1'b0;
    #1;
    check("rst_d0_valid", d0_valid, 0);
    check("rst_d1_valid", d1_valid, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_d0_pc", d0_pc, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic ins_t mk_add(logic [4:0] d, logic [4:0] a, logic [4:0] b, logic [31:0] pc);
    return '{nop: 0, mem_wen: 0, int_wen: 1, fp_wen: 0, opcode: 6'h20, detail: 3'd0,
             rel: 4'b0011, src_a: a, src_b: b, dest: d, pc: pc};
  endfunction

  function automatic ins_t mk_nop(logic [31:0] pc);
    ins_t x = '0;
    x.nop = 1; x.pc = pc;
    return x;
  endfunction

  function automatic ins_t mk_rand(logic [31:0] pc);
    ins_t x = ins_t'({$urandom, $urandom});
    int k = $urandom_range(0, 3);
    x.nop = ($urandom_range(0, 7) == 0);
    x.int_wen = (k < 2); x.fp_wen = (k == 2);
    x.src_a = 5'($urandom_range(0, 7));
    x.src_b = 5'($urandom_range(0, 7));
    x.dest  = 5'($urandom_range(0, 7));
    x.pc = pc;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pc = 32'h1000;
    do_reset();

    // Reset then a ready pair: read that cycle, both dispatch one cycle later.
    iq.push_back('{mk_add(3, 1, 2, 32'h100), mk_add(6, 4, 5, 32'h104)});
    c_qgate = 1; step();
    check("t1_read_en", last_read, 1);
    c_qgate = 0; step(); #2;
    check("t2_d0_valid", d0_valid, 1);
    check("t2_d1_valid", d1_valid, 1);
    check("t2_d0_pc", d0_pc, 32'h100);
    check("t2_d1_pc", d1_pc, 32'h104);
    check("t2_model_busy_r3", ib[3], 1);
    check("t2_model_busy_r6", ib[6], 1);
    c_wbi = 1; c_wbi_reg = 3; step();
    c_wbi_reg = 6; step();
    c_wbi = 0;

    // In-pair RAW on r3: inst1 alone, then inst2 after the writeback (no bypass).
    iq.push_back('{mk_add(3, 1, 2, 32'h108), mk_add(8, 3, 2, 32'h10c)});
    iq.push_back('{mk_nop(32'h110), mk_nop(32'h114)});
    iq.push_back('{mk_add(9, 1, 2, 32'h118), mk_add(10, 1, 2, 32'h11c)});
    c_qgate = 1; step();
    step();
    check("t3_read_en_raw", last_read, 0); #2;
    check("t3_d0_valid", d0_valid, 1);
    check("t3_d0_pc", d0_pc, 32'h108);
    check("t3_d1_valid", d1_valid, 0);
    c_wbi = 1; c_wbi_reg = 3; step();
    check("t3_read_en_wb", last_read, 0); #2;
    check("t3_no_bypass", d0_valid, 0);
    c_wbi = 0; step();
    check("t3_read_en_go", last_read, 1); #2;
    check("t3_d0_valid_after_wb", d0_valid, 1);
    check("t3_d0_pc_after_wb", d0_pc, 32'h10c);

    // Nop pair retires silently and refills in the same cycle.
    step();
    check("t5_read_en", last_read, 1); #2;
    check("t5_d0_valid", d0_valid, 0);
    check("t5_d1_valid", d1_valid, 0);
    c_qgate = 0; step();

    // Port0 not ready for three cycles.
    do_reset();
    iq.push_back('{mk_add(11, 1, 2, 32'h200), mk_add(12, 4, 5, 32'h204)});
    c_qgate = 1; step();
    c_qgate = 0; c_ex0 = 0;
    repeat (3) begin
      step();
      check("t4_read_en", last_read, 0);
    end
    #2;
    check("t4_stall", stall_cnt, 3);
    check("t4_d0_valid", d0_valid, 0);
    c_ex0 = 1; step(); #2;
    check("t4_d0_valid_go", d0_valid, 1);
    check("t4_d1_valid_go", d1_valid, 1);

    // Flush a hazarded pair; scoreboard survives until a writeback.
    iq.push_back('{mk_add(13, 11, 2, 32'h208), mk_add(14, 1, 2, 32'h20c)});
    c_qgate = 1; step();
    c_qgate = 0; c_flush = 1; step();
    c_flush = 0; #2;
    check("t6_d0_valid", d0_valid, 0);
    check("t6_d1_valid", d1_valid, 0);
    check("t6_model_busy_r11", ib[11], 1);
    iq.push_back('{mk_add(15, 11, 1, 32'h210), mk_nop(32'h214)});
    c_qgate = 1; step();
    check("t6_idle_read", last_read, 1);
    c_qgate = 0; step(); #2;
    check("t6_busy_blocks", d0_valid, 0);
    c_wbi = 1; c_wbi_reg = 11; step();
    c_wbi = 0; step(); #2;
    check("t6_after_wb_valid", d0_valid, 1);
    check("t6_after_wb_pc", d0_pc, 32'h210);

    // Random traffic with an asynchronous reset in the middle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (iq.size() < 4) begin
        iq.push_back('{mk_rand(pc), mk_rand(pc + 4)});
        pc += 8;
      end
      c_qgate   = ($urandom_range(0, 3) != 0);
      c_ex0     = ($urandom_range(0, 3) != 0);
      c_ex1     = ($urandom_range(0, 3) != 0);
      c_wbi     = ($urandom_range(0, 2) == 0);
      c_wbi_reg = 5'($urandom_range(0, 7));
      c_wbf     = ($urandom_range(0, 2) == 0);
      c_wbf_reg = 5'($urandom_range(0, 7));
      c_flush   = ($urandom_range(0, 29) == 0);
      step();
      if (cyc == 1500) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
